cpu_mem_responder: RTL and testbench
====================================

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic is on the rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: cpu_req  input  1  one-cycle pulse; ab/dout/we are valid this cycle.
REQ-004 SHALL have ports: ab  input  16  CPU address; dout  input  8  CPU write data; we  input  1  write when 1.
REQ-005 SHALL have port: port_bits  input  3  6510 port output, bit0 LORAM, bit1 HIRAM, bit2 CHAREN.
REQ-006 SHALL have ports: di  output  8  CPU read data; rdy  output  1  CPU ready, low stalls the CPU.
REQ-007 SHALL have ports: mem_req  output  1; mem_addr  output  17; mem_we  output  1; mem_wdata  output  8; mem_ack  input  1; mem_rdata  input  8.
REQ-008 SHALL have ports: io_cs  output  1  one-cycle IO strobe; io_rdata  input  8  IO read data.
REQ-009 SHALL have port: err  output  1  sticky memory-timeout flag.

Function
REQ-010 SHALL be in state IDLE when accepting cpu_req; cpu_req in any other state SHALL be ignored.
REQ-011 SHALL decode a read with LORAM=HIRAM=1 at A000-BFFF to BASIC ROM, mem_addr = 0x10000 + ab[12:0].
REQ-012 SHALL decode a read with HIRAM=1 at E000-FFFF to KERNAL ROM, mem_addr = 0x12000 + ab[12:0].
REQ-013 SHALL decode D000-DFFF with (LORAM|HIRAM)=1 as IO when CHAREN=1 (reads and writes), or as CHAR ROM on reads when CHAREN=0, mem_addr = 0x14000 + ab[11:0].
REQ-014 SHALL map every other access, and all writes to ROM regions, to RAM with mem_addr = {1'b0, ab}.
REQ-015 SHALL, for a memory access, go IDLE->MEM_WAIT in the cycle after cpu_req, drive mem_req=1, rdy=0 and hold mem_addr/mem_we/mem_wdata stable until mem_ack.
REQ-016 SHALL, on mem_ack in MEM_WAIT, capture mem_rdata into di (reads only; di unchanged on writes), drop mem_req, and raise rdy in the following cycle, returning to IDLE.
REQ-017 SHALL, for an IO access, go IDLE->IO_WAIT, pulse io_cs for exactly one cycle with rdy=0, capture io_rdata into di at the end of that cycle on reads, and return to IDLE with rdy=1.
REQ-018 SHALL count MEM_WAIT cycles in an 8-bit counter; at count 255 without mem_ack it SHALL drop mem_req, set di=0xFF on reads, set err=1, and return to IDLE with rdy=1.
REQ-019 SHALL treat mem_ack arriving in the same cycle as the timeout as a normal completion (ack wins, err unchanged).
REQ-020 SHALL sample port_bits only on the cpu_req cycle; port_bits changes during a transaction SHALL not affect it.
REQ-021 SHALL ignore mem_ack outside MEM_WAIT.

Reset
REQ-022 SHALL on reset immediately force IDLE, rdy=1, di=0x00, mem_req=0, mem_we=0, io_cs=0, err=0, counter=0, aborting any transaction in progress.

Configuration
REQ-023 SHALL, with BANKING_EN defined, apply REQ-011..REQ-013; without it, every access SHALL map to RAM per REQ-014, io_cs SHALL be constant 0 and port_bits SHALL be ignored.

Structure
REQ-024 SHALL take the state encoding (IDLE, MEM_WAIT, IO_WAIT), the ROM base addresses and the timeout limit from the shared package cpu_bus_pkg.
REQ-025 SHALL place the address decode of REQ-011..REQ-014 in one combinational sub-module, bank_decode.

Verification
REQ-026 SHALL check: port_bits=7, read ab=0xA123, mem_ack after 3 cycles with 0x5A -> mem_addr=0x10123, rdy low 4 cycles, di=0x5A.
REQ-027 SHALL check: port_bits=7, write ab=0xE000 dout=0x33 -> mem_addr=0x0E000, mem_we=1, mem_wdata=0x33, di unchanged.
REQ-028 SHALL check: port_bits=7, read ab=0xD020, io_rdata=0x0E -> single io_cs pulse, no mem_req, di=0x0E, rdy low 1 cycle.
REQ-029 SHALL check: read with mem_ack never asserted -> mem_req drops after 255 cycles, di=0xFF, err=1, rdy=1.
REQ-030 SHALL check: reset asserted during MEM_WAIT -> mem_req=0, rdy=1 without waiting for clk; next cpu_req is served normally.
REQ-031 SHALL check: with BANKING_EN undefined, read ab=0xD000 with port_bits=7 -> mem_addr=0x0D000, io_cs stays 0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for cpu_mem_responder: FSM encoding, ROM bases, timeout.
// BANKING_EN selects C64-style ROM/IO banking; when undefined all accesses are flat RAM.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    IO_WAIT  = 2'd2
  } state_e;

  localparam logic [16:0] BASIC_BASE    = 17'h10000;
  localparam logic [16:0] KERNAL_BASE   = 17'h12000;
  localparam logic [16:0] CHAR_BASE     = 17'h14000;
  localparam logic [7:0]  TIMEOUT_LIMIT = 8'd255;

`ifdef BANKING_EN
  localparam logic BANKING_ON = 1'b1;
`else
  localparam logic BANKING_ON = 1'b0;
`endif

endpackage

// File: rtl/bank_decode.sv
// Combinational CPU address decode into the 17-bit backing-store space plus IO select.
// With BANKING_EN undefined the map is flat RAM and port bits are ignored.
module bank_decode
  import cpu_bus_pkg::*;
(
  input  logic [15:0] ab_i,
  input  logic        we_i,
  input  logic [2:0]  port_bits_i,
  output logic [16:0] addr_o,
  output logic        io_o
);

`ifdef BANKING_EN
  logic loram, hiram, charen;

  assign loram  = port_bits_i[0];
  assign hiram  = port_bits_i[1];
  assign charen = port_bits_i[2];

  // ROM windows only capture reads; writes fall through to the RAM underneath.
  always_comb begin
    addr_o = {1'b0, ab_i};
    io_o   = 1'b0;
    if (!we_i && loram && hiram && (ab_i[15:13] == 3'b101)) begin
      addr_o = BASIC_BASE + {4'd0, ab_i[12:0]};
    end else if (!we_i && hiram && (ab_i[15:13] == 3'b111)) begin
      addr_o = KERNAL_BASE + {4'd0, ab_i[12:0]};
    end else if ((ab_i[15:12] == 4'hD) && (loram || hiram)) begin
      if (charen) begin
        io_o = 1'b1;
      end else if (!we_i) begin
        addr_o = CHAR_BASE + {5'd0, ab_i[11:0]};
      end
    end
  end
`else
  logic unused_decode;

  assign unused_decode = ^{we_i, port_bits_i};
  assign addr_o        = {1'b0, ab_i};
  assign io_o          = 1'b0;
`endif

endmodule

// File: rtl/cpu_mem_responder.sv
// Serves single CPU accesses from backing memory or IO with a stall/ready handshake.
// BANKING_EN enables ROM/IO banking via bank_decode; otherwise flat RAM, io_cs tied low.
module cpu_mem_responder
  import cpu_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] ab,
  input  logic [7:0]  dout,
  input  logic        we,
  input  logic [2:0]  port_bits,
  output logic [7:0]  di,
  output logic        rdy,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        io_cs,
  input  logic [7:0]  io_rdata,
  output logic        err
);

  state_e      state_q, state_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  di_q, di_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [16:0] dec_addr;
  logic        dec_io;

  bank_decode u_bank_decode (
    .ab_i        (ab),
    .we_i        (we),
    .port_bits_i (port_bits),
    .addr_o      (dec_addr),
    .io_o        (dec_io)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      di_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      di_q    <= di_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    di_d    = di_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdy     = 1'b1;
    mem_req = 1'b0;
    io_cs   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = dec_addr;
          wdata_d = dout;
          we_d    = we;
          cnt_d   = 8'd1;
          state_d = dec_io ? IO_WAIT : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        rdy     = 1'b0;
        mem_req = 1'b1;
        // A late ack in the timeout cycle still completes normally.
        if (mem_ack) begin
          if (!we_q) di_d = mem_rdata;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_LIMIT) begin
          if (!we_q) di_d = 8'hFF;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      IO_WAIT: begin
        rdy   = 1'b0;
        io_cs = BANKING_ON;
        if (!we_q) di_d = io_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = (state_q == MEM_WAIT) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign di        = di_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized scoreboard bench for cpu_mem_responder against a behavioural memory-map model.
// Follows BANKING_EN the same way as the design so either build can be checked.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [15:0] ab = '0;
  logic [7:0]  dout = '0;
  logic        we = 1'b0;
  logic [2:0]  port_bits = '0;
  logic [7:0]  di;
  logic        rdy;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        io_cs;
  logic [7:0]  io_rdata = '0;
  logic        err;

  cpu_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .ab        (ab),
    .dout      (dout),
    .we        (we),
    .port_bits (port_bits),
    .di        (di),
    .rdy       (rdy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .io_cs     (io_cs),
    .io_rdata  (io_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          io;
    logic [16:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  di;
    logic        err;
    logic [8:0]  stall;
  } exp_t;

  exp_t       expq[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_di = 8'h00;
  logic       model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Memory map written as address ranges rather than bit slices.
  function automatic void model_map(input int a, input logic w, input logic [2:0] pb,
                                    output logic [16:0] addr, output bit io);
    addr = 17'(a);
    io   = 1'b0;
`ifdef BANKING_EN
    if (!w && pb[0] && pb[1] && a >= 'hA000 && a <= 'hBFFF)
      addr = 17'('h10000 + (a - 'hA000));
    else if (!w && pb[1] && a >= 'hE000 && a <= 'hFFFF)
      addr = 17'('h12000 + (a - 'hE000));
    else if (a >= 'hD000 && a <= 'hDFFF && (pb[0] || pb[1])) begin
      if (pb[2]) io = 1'b1;
      else if (!w) addr = 17'('h14000 + (a - 'hD000));
    end
`endif
  endfunction

  task automatic scramble();
    cpu_req   = 1'($urandom);
    ab        = 16'($urandom);
    dout      = 8'($urandom);
    we        = 1'($urandom);
    port_bits = 3'($urandom);
  endtask

  // ack_delay: cycles of mem_req before ack; negative or >254 means never acked.
  task automatic do_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic [2:0] pb, input int ack_delay,
                        input logic [7:0] rd, input logic [7:0] iod);
    logic [16:0] maddr;
    bit          io;
    bit          tmo;
    int          stall;
    exp_t        e;
    model_map(int'(a), w, pb, maddr, io);
    tmo   = !(ack_delay >= 0 && ack_delay <= 254);
    stall = io ? 1 : (tmo ? 255 : ack_delay + 1);
    e.io    = io;
    e.addr  = maddr;
    e.we    = w;
    e.wdata = d;
    if (w)       e.di = model_di;
    else if (io) e.di = iod;
    else         e.di = tmo ? 8'hFF : rd;
    model_di  = e.di;
    model_err = model_err | (tmo && !io);
    e.err   = model_err;
    e.stall = 9'(stall);

    @(posedge clk); #1;
    cpu_req = 1'b1; ab = a; dout = d; we = w; port_bits = pb; mem_ack = 1'b0;
    expq.push_back(e);
    for (int k = 1; k <= stall; k++) begin
      @(posedge clk); #1;
      scramble();
      if (io) begin
        io_rdata  = iod;
        mem_ack   = 1'($urandom);
        mem_rdata = 8'($urandom);
      end else begin
        io_rdata  = 8'($urandom);
        mem_ack   = (k == stall) && !tmo;
        mem_rdata = mem_ack ? rd : 8'($urandom);
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cpu_req   = 1'b0;
      mem_ack   = 1'($urandom);
      mem_rdata = 8'($urandom);
      port_bits = 3'($urandom);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin : monitor
    int          stall = 0;
    int          nreq = 0;
    int          nio = 0;
    bit          prev_rdy = 1'b1;
    bit          prev_req = 1'b0;
    bit          stable = 1'b1;
    logic [16:0] first_addr = '0;
    logic        first_we = 1'b0;
    logic [7:0]  first_wdata = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 0; nreq = 0; nio = 0;
        prev_rdy = 1'b1; prev_req = 1'b0; stable = 1'b1;
        continue;
      end
      if (mem_req) begin
        nreq++;
        if (!prev_req) begin
          first_addr = mem_addr; first_we = mem_we; first_wdata = mem_wdata;
          chk("mem_req_has_expectation", 32'(expq.size() != 0), 32'd1);
          if (expq.size() != 0) begin
            e = expq[0];
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          end
        end else if (mem_addr !== first_addr || mem_we !== first_we ||
                     mem_wdata !== first_wdata) begin
          stable = 1'b0;
        end
      end
      if (io_cs) nio++;
      if (!rdy) stall++;
      if (rdy && !prev_rdy) begin
        chk("completion_has_expectation", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("rdy_low_cycles", 32'(stall), 32'(e.stall));
          chk("di", 32'(di), 32'(e.di));
          chk("err", 32'(err), 32'(e.err));
          chk("io_cs_pulses", 32'(nio), e.io ? 32'd1 : 32'd0);
          chk("mem_req_cycles", 32'(nreq), e.io ? 32'd0 : 32'(e.stall));
          chk("mem_bus_stable", 32'(stable), 32'd1);
        end
        stall = 0; nreq = 0; nio = 0; stable = 1'b1;
      end
      prev_rdy = rdy;
      prev_req = mem_req;
    end
  end

  initial begin : stimulus
    logic [3:0] his[11];
    his = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h8, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(rdy), 32'd1);
    chk("reset_di", 32'(di), 32'h00);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_io_cs", 32'(io_cs), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    reset = 1'b0;
    idle_gap(2);

    do_txn(1'b0, 16'hA123, 8'h00, 3'd7, 3, 8'h5A, 8'h00);
    do_txn(1'b1, 16'hE000, 8'h33, 3'd7, 1, 8'hC3, 8'h00);
    do_txn(1'b0, 16'hD020, 8'h00, 3'd7, 2, 8'h77, 8'h0E);
    do_txn(1'b0, 16'hD000, 8'h00, 3'd7, 0, 8'h91, 8'h44);
    do_txn(1'b0, 16'hF000, 8'h00, 3'd2, 4, 8'h6C, 8'h00);
    do_txn(1'b0, 16'hD800, 8'h00, 3'd1, 1, 8'h2B, 8'h00);
    do_txn(1'b1, 16'hD400, 8'h12, 3'd3, 2, 8'h00, 8'h00);
    do_txn(1'b0, 16'hD400, 8'h00, 3'd0, 1, 8'h3D, 8'hE7);
    idle_gap(3);

    do_txn(1'b0, 16'h4000, 8'h00, 3'd7, 254, 8'hA5, 8'h00);
    do_txn(1'b0, 16'h4001, 8'h00, 3'd7, -1, 8'h00, 8'h00);
    do_txn(1'b1, 16'h4002, 8'h99, 3'd7, -1, 8'h00, 8'h00);

    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom), {his[$urandom_range(0, 10)], 12'($urandom)}, 8'($urandom),
             3'($urandom), $urandom_range(0, 6), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a memory wait.
    @(posedge clk); #1;
    cpu_req = 1'b1; ab = 16'h1234; we = 1'b0; port_bits = 3'd7; mem_ack = 1'b0;
    expq.push_back('{io: 1'b0, addr: 17'h01234, we: 1'b0, wdata: 8'h00,
                     di: 8'h00, err: 1'b0, stall: 9'd0});
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_reset_mem_req", 32'(mem_req), 32'd0);
    chk("async_reset_rdy", 32'(rdy), 32'd1);
    chk("async_reset_mem_we", 32'(mem_we), 32'd0);
    chk("async_reset_di", 32'(di), 32'h00);
    chk("async_reset_err", 32'(err), 32'd0);
    expq.delete();
    model_di  = 8'h00;
    model_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    do_txn(1'b0, 16'hA123, 8'h00, 3'd7, 2, 8'h4E, 8'h00);
    do_txn(1'b0, 16'hD020, 8'h00, 3'd7, 1, 8'h61, 8'h0E);
    idle_gap(4);

    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
